mps_axil_cmd_master: RTL and testbench
======================================

MPS_AXIL_CMD_MASTER -- requirements
Module: mps_axil_cmd_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the AXI4-Lite data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, the AXI4-Lite byte address width (20 registers).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, the per-transaction timeout in i_clk cycles.
REQ-004 SHALL have port i_clk, input, 1 bit: the clock.
REQ-005 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_cmd_valid, input, 1 bit: command request.
REQ-007 SHALL have port o_cmd_ready, output, 1 bit: command accepted when high together with i_cmd_valid.
REQ-008 SHALL have port i_cmd_wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port i_cmd_addr, input, ADDR_WIDTH bits: register byte address.
REQ-010 SHALL have port i_cmd_wdata, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port o_rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port o_rsp_rdata, output, DATA_WIDTH bits: read data, held until the next read completes.
REQ-013 SHALL have port o_rsp_err, output, 2 bits: 0 = OKAY, 1 = SLVERR or DECERR, 2 = timeout.
REQ-014 SHALL have write-address ports m_axi_awaddr (output, ADDR_WIDTH), m_axi_awprot (output, 3), m_axi_awvalid (output, 1) and m_axi_awready (input, 1).
REQ-015 SHALL have write-data ports m_axi_wdata (output, DATA_WIDTH), m_axi_wstrb (output, DATA_WIDTH/8), m_axi_wvalid (output, 1) and m_axi_wready (input, 1).
REQ-016 SHALL have write-response ports m_axi_bresp (input, 2), m_axi_bvalid (input, 1) and m_axi_bready (output, 1).
REQ-017 SHALL have read-address ports m_axi_araddr (output, ADDR_WIDTH), m_axi_arprot (output, 3), m_axi_arvalid (output, 1) and m_axi_arready (input, 1).
REQ-018 SHALL have read-data ports m_axi_rdata (input, DATA_WIDTH), m_axi_rresp (input, 2), m_axi_rvalid (input, 1) and m_axi_rready (output, 1).

Function
REQ-019 SHALL implement the FSM IDLE, WR_AD, WR_B, RD_A, RD_R, DONE; o_cmd_ready SHALL be 1 only in IDLE.
REQ-020 On accept in cycle N (IDLE, valid, wr=1), SHALL register the address and data and enter WR_AD, with awvalid and wvalid high from N+1.
REQ-021 In WR_AD, awvalid and wvalid SHALL each drop independently on their own handshake, in either order or in the same cycle; the FSM SHALL enter WR_B after both complete.
REQ-022 In WR_B, bready SHALL be 1; on bvalid, SHALL capture bresp and enter DONE.
REQ-023 On a read accept, SHALL enter RD_A with arvalid high from N+1; on arready, SHALL enter RD_R; rready SHALL be 1 in RD_R; on rvalid, SHALL capture rdata and rresp and enter DONE.
REQ-024 In DONE, o_rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; a zero-wait slave gives write completion at N+3 and read completion at N+3.
REQ-025 awprot and arprot SHALL be 3'b000 and wstrb SHALL be all ones.
REQ-026 No AXI valid SHALL be deasserted before its handshake, except on timeout.
REQ-027 A timeout counter SHALL clear on accept and increment in every non-IDLE, non-DONE state; on reaching TIMEOUT_CYC-1, all valids and readies SHALL drop, o_rsp_err SHALL be 2, and the FSM SHALL enter DONE.
REQ-028 If timeout and a handshake occur in the same cycle, the handshake SHALL win.
REQ-029 o_rsp_err SHALL be 1 when the captured resp[1] is 1, and 0 otherwise.
REQ-030 A read that ends in error SHALL still update o_rsp_rdata.
REQ-031 i_cmd_valid outside IDLE SHALL be ignored, with no queuing.

Reset
REQ-032 While i_rst is 0, the FSM SHALL be in IDLE, and all outputs, the counter and the registers SHALL be 0 (o_cmd_ready 0).
REQ-033 o_cmd_ready SHALL rise on the first clock after i_rst deasserts.
REQ-034 Reset mid-transaction SHALL abort the transaction immediately with no o_rsp_valid.

Structure
REQ-035 The state encoding and the o_rsp_err codes SHALL be defined as constants in the shared MPS package.
REQ-036 The timeout counter SHALL be the sub-module mps_timeout_cnt (clear, enable, expire).

Verification
REQ-037 Zero-wait write to 0x08 with data 0xA5A5_0001: o_rsp_valid at N+3, err 0, AW and W beats carry the command values.
REQ-038 wready delayed 5 cycles after awready: awvalid drops first, completion at N+8, err 0.
REQ-039 Read of 0x10 with rdata 0x1234_5678 and rvalid delayed 3 cycles: o_rsp_rdata 0x1234_5678, err 0.
REQ-040 Read with rresp 2'b10: err 1, and rdata is updated.
REQ-041 Slave never asserts arready with TIMEOUT_CYC = 16: arvalid drops, err 2, and o_cmd_ready returns.
REQ-042 i_rst pulsed low while in WR_B: all outputs 0, no rsp pulse, and a fresh write then completes normally.

Source files
------------

// File: rtl/mps_axil_cmd_master_pkg.sv
// Shared constants for the AXI4-Lite command master: FSM state encoding,
// response error codes and the bus-response to error-code mapping.
package mps_axil_cmd_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR_AD = 3'd1,
      ST_WR_B  = 3'd2,
      ST_RD_A  = 3'd3,
      ST_RD_R  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [1:0] ERR_OKAY    = 2'd0;
   localparam logic [1:0] ERR_SLV     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   // SLVERR (2'b10) and DECERR (2'b11) both report as a slave error.
   function automatic logic [1:0] resp_to_err(input logic [1:0] resp);
      return (resp inside {2'b10, 2'b11}) ? ERR_SLV : ERR_OKAY;
   endfunction

endpackage

// File: rtl/mps_timeout_cnt.sv
// Per-transaction watchdog: cleared on command accept, counts while enabled,
// flags expiry on the cycle it holds TIMEOUT_CYC-1.
module mps_timeout_cnt #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] r_cnt;

   // Saturates at LAST so a handshake that beats expiry cannot wrap the count.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/mps_axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one read/write command into a bus
// transaction and reports completion, slave error or timeout.
module mps_axil_cmd_master
   import mps_axil_cmd_master_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 7,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic                    i_cmd_wr,
   input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
   output logic                    o_rsp_valid,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic [1:0]              o_rsp_err,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   state_t                r_state;
   logic                  r_cmd_ready;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_rsp_valid;
   logic [1:0]            r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic w_accept;
   logic w_busy;
   logic w_expire;
   logic w_aw_done;
   logic w_w_done;

   assign w_accept  = r_cmd_ready && i_cmd_valid;
   assign w_busy    = (r_state == ST_WR_AD) || (r_state == ST_WR_B) ||
                      (r_state == ST_RD_A)  || (r_state == ST_RD_R);
   assign w_aw_done = !r_awvalid || m_axi_awready;
   assign w_w_done  = !r_wvalid  || m_axi_wready;

   mps_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (w_accept),
      .i_enable (w_busy),
      .o_expire (w_expire)
   );

   // Every branch checks its handshake before expiry, so a late handshake wins.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= ERR_OKAY;
         r_rsp_rdata <= '0;
         r_wdata     <= '0;
         r_addr      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= i_cmd_addr;
                  if (i_cmd_wr) begin
                     r_wdata   <= i_cmd_wdata;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR_AD;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_A;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            ST_WR_AD: begin
               if (w_aw_done && w_w_done) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= ST_WR_B;
               end else if (w_expire) begin
                  r_awvalid   <= 1'b0;
                  r_wvalid    <= 1'b0;
                  r_rsp_err   <= ERR_TIMEOUT;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  if (m_axi_awready) r_awvalid <= 1'b0;
                  if (m_axi_wready)  r_wvalid  <= 1'b0;
               end
            end
            ST_WR_B: begin
               if (m_axi_bvalid || w_expire) begin
                  r_bready    <= 1'b0;
                  r_rsp_err   <= m_axi_bvalid ? resp_to_err(m_axi_bresp) : ERR_TIMEOUT;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_RD_A: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_R;
               end else if (w_expire) begin
                  r_arvalid   <= 1'b0;
                  r_rsp_err   <= ERR_TIMEOUT;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_RD_R: begin
               if (m_axi_rvalid) begin
                  r_rready    <= 1'b0;
                  r_rsp_rdata <= m_axi_rdata;
                  r_rsp_err   <= resp_to_err(m_axi_rresp);
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else if (w_expire) begin
                  r_rready    <= 1'b0;
                  r_rsp_err   <= ERR_TIMEOUT;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cmd_ready   = r_cmd_ready;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_rsp_err     = r_rsp_err;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_mps_axil_cmd_master.sv
// Scoreboard bench for mps_axil_cmd_master: directed commands against a
// delay-configurable AXI4-Lite slave, responses checked by a separate monitor.
module tb_mps_axil_cmd_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
   logic [6:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready, rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic [6:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [31:0] rdata = '0;

   mps_axil_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .TIMEOUT_CYC(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0, n_rsp = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  err;
      logic        chk_rd;
      logic [31:0] rdata;
   } exp_t;
   exp_t q[$];

   // slave configuration: cycles of valid/ready seen before answering
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = '0;
   logic [6:0]  exp_addr = '0;
   logic [31:0] exp_wdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // AXI slave model, driven on the falling edge
   initial begin
      int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
      forever begin
         @(negedge clk);
         if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end else begin awready = 1'b0; aw_c = 0; end
         if (wvalid)  begin wready  = (w_c  >= w_dly);  w_c++;  end else begin wready  = 1'b0; w_c  = 0; end
         if (arvalid) begin arready = (ar_c >= ar_dly); ar_c++; end else begin arready = 1'b0; ar_c = 0; end
         if (bready)  begin bvalid  = (b_c  >= b_dly);  b_c++;  end else begin bvalid  = 1'b0; b_c  = 0; end
         if (rready)  begin rvalid  = (r_c  >= r_dly);  r_c++;  end else begin rvalid  = 1'b0; r_c  = 0; end
         bresp = cfg_bresp;
         rresp = cfg_rresp;
         rdata = cfg_rdata;
         if (awvalid && awready) begin
            chk("aw_beat", {54'd0, awprot, awaddr}, {54'd0, 3'b000, exp_addr});
         end
         if (wvalid && wready) begin
            chk("w_beat", {28'd0, wstrb, wdata}, {28'd0, 4'hF, exp_wdata});
         end
         if (arvalid && arready) begin
            chk("ar_beat", {54'd0, arprot, araddr}, {54'd0, 3'b000, exp_addr});
         end
      end
   end

   // response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rsp_unexpected: got a response with err %0d, expected none (cycle %0d)", rsp_err, cyc);
            end else begin
               e = q.pop_front();
               chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
               chk("rsp_err", {62'd0, rsp_err}, {62'd0, e.err});
               if (e.chk_rd) chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
            end
         end
      end
   end

   task automatic issue(input logic wr, input logic [6:0] a, input logic [31:0] d, output int n);
      int k;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
      exp_addr = a; exp_wdata = d;
      k = 0;
      while (cmd_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (cmd_ready !== 1'b1) chk("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
      n = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic expect_rsp(input int c, input logic [1:0] err, input logic chk_rd, input logic [31:0] d);
      q.push_back('{cyc: c, err: err, chk_rd: chk_rd, rdata: d});
   endtask

   task automatic wait_rsp();
      int start = n_rsp;
      for (int i = 0; i < 40 && n_rsp == start; i++) @(negedge clk);
      @(negedge clk);
      if (n_rsp == start) chk("rsp_wait_timeout", 64'(n_rsp), 64'(start + 1));
   endtask

   logic [63:0] all_out;
   assign all_out = {cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready,
                     awaddr[6:0], rsp_rdata[31:8]} | {40'd0, wdata[23:0]};

   initial begin
      int n, saved;
      // reset state
      #12;
      chk("reset_outputs", all_out, 64'd0);
      @(negedge clk); @(negedge clk);
      chk("ready_in_reset", {63'd0, cmd_ready}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

      // zero-wait write
      issue(1'b1, 7'h08, 32'hA5A5_0001, n);
      expect_rsp(n + 3, 2'd0, 1'b0, '0);
      wait_rsp();

      // wready 5 cycles after awready: AW drops first
      w_dly = 5;
      issue(1'b1, 7'h0C, 32'h0000_BEEF, n);
      expect_rsp(n + 8, 2'd0, 1'b0, '0);
      @(negedge clk);
      chk("aw_first_drop", {62'd0, awvalid, wvalid}, {62'd0, 1'b0, 1'b1});
      wait_rsp();
      w_dly = 0;

      // read with rvalid delayed 3 cycles
      r_dly = 3; cfg_rdata = 32'h1234_5678;
      issue(1'b0, 7'h10, '0, n);
      expect_rsp(n + 6, 2'd0, 1'b1, 32'h1234_5678);
      wait_rsp();
      r_dly = 0;

      // read answered with SLVERR still updates rdata
      cfg_rresp = 2'b10; cfg_rdata = 32'hDEAD_BEEF;
      issue(1'b0, 7'h14, '0, n);
      expect_rsp(n + 3, 2'd1, 1'b1, 32'hDEAD_BEEF);
      wait_rsp();

      // EXOKAY (resp[1]=0) reports OKAY
      cfg_rresp = 2'b01; cfg_rdata = 32'h0BAD_F00D;
      issue(1'b0, 7'h18, '0, n);
      expect_rsp(n + 3, 2'd0, 1'b1, 32'h0BAD_F00D);
      wait_rsp();
      cfg_rresp = 2'b00;

      // W before AW, DECERR on B
      aw_dly = 2; cfg_bresp = 2'b11;
      issue(1'b1, 7'h1C, 32'h7777_0003, n);
      expect_rsp(n + 5, 2'd1, 1'b0, '0);
      wait_rsp();
      aw_dly = 0; cfg_bresp = 2'b00;

      // cmd_valid while busy is ignored
      w_dly = 4;
      issue(1'b1, 7'h04, 32'h0000_1111, n);
      expect_rsp(n + 7, 2'd0, 1'b0, '0);
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 7'h20;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("busy_ignore", {61'd0, cmd_ready, arvalid, wvalid}, {61'd0, 1'b0, 1'b0, 1'b1});
      cmd_valid = 1'b0;
      wait_rsp();
      w_dly = 0;

      // timeout: arready never comes
      ar_dly = 1000;
      issue(1'b0, 7'h20, '0, n);
      expect_rsp(n + 17, 2'd2, 1'b0, '0);
      for (int i = 0; i < 15; i++) @(negedge clk);
      chk("arvalid_held", {63'd0, arvalid}, 64'd1);
      @(negedge clk);
      chk("arvalid_timeout_drop", {63'd0, arvalid}, 64'd0);
      @(negedge clk);
      chk("ready_after_timeout", {63'd0, cmd_ready}, 64'd1);
      ar_dly = 0;

      // reset pulsed while waiting in WR_B
      b_dly = 100;
      issue(1'b1, 7'h28, 32'hCAFE_0004, n);
      @(negedge clk);
      chk("in_wr_b", {63'd0, bready}, 64'd1);
      saved = n_rsp;
      rst = 1'b0;
      #1;
      chk("mid_reset_outputs", all_out, 64'd0);
      b_dly = 0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("no_rsp_on_reset", 64'(n_rsp), 64'(saved));
      chk("ready_after_mid_reset", {63'd0, cmd_ready}, 64'd1);

      // fresh write after reset
      issue(1'b1, 7'h24, 32'h5A5A_0002, n);
      expect_rsp(n + 3, 2'd0, 1'b0, '0);
      wait_rsp();

      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
